post_trace_array: RTL and testbench
===================================

POST_TRACE_ARRAY -- requirements
Module: post_trace_array

Interface
REQ-001 The block SHALL have parameter N_NEURON, default 18: number of post-synaptic neurons per timestep.
REQ-002 The block SHALL have parameter IDX_W, default 5: neuron index width, with 2^IDX_W >= N_NEURON.
REQ-003 The block SHALL have parameter TRACE_W, default 16: width of each trace.
REQ-004 The block SHALL have parameter CNT_W, default 7: width of each spike counter.
REQ-005 The block SHALL have parameters Y1_SHIFT and Y2_SHIFT, defaults 4 and 5: decay shifts of y1 and y2.
REQ-006 The block SHALL have parameter TRACE_MODE, default 0: 0 = set-to-max on spike, 1 = additive saturating on spike.
REQ-007 The block SHALL have parameter Y_INC, default 16384: increment applied in additive mode.
REQ-008 The block SHALL have these ports:
 clk  in  1  sole clock, rising edge
 reset_n  in  1  asynchronous active-low reset
 i_valid  in  1  one neuron update result present
 i_spike  in  1  spike flag of that neuron
 i_neuron_idx  in  IDX_W  neuron index of that result
 i_s_init  in  1  synchronous full clear (init)
 i_cnt_clr  in  1  synchronous clear of spike counters only
 o_spike_buffer  out  N_NEURON  spikes captured in the current step
 o_y1_trace  out  N_NEURON*TRACE_W  fast traces; neuron k at [k*TRACE_W +: TRACE_W]
 o_y2_trace_buf  out  N_NEURON*TRACE_W  y2 values as they stood before the last commit
 o_inhbt  out  IDX_W  index of the first neuron to spike in the step
 o_inhbt_valid  out  1  o_inhbt is meaningful
 o_post_cnt  out  N_NEURON*CNT_W  per-neuron saturating spike counts
 o_valid  out  1  one-cycle pulse: step committed

Function
REQ-009 On each i_valid with idx < N_NEURON, the block SHALL OR i_spike into spike_buffer[idx] at the next edge; results with idx >= N_NEURON SHALL be ignored and SHALL not count toward the step.
REQ-010 A step counter SHALL count accepted results; when the N_NEURON-th result is accepted, the following cycle SHALL be the commit cycle and the counter SHALL return to 0.
REQ-011 In the commit cycle, all neurons SHALL be updated in parallel; o_valid SHALL be high for exactly that cycle, giving a latency of 1 cycle from the last accepted result.
REQ-012 Trace update with s = spike_buffer[k]: decay d(y) = y - (y >> SHIFT); TRACE_MODE 0: y_new = s ? 2^TRACE_W-1 : d(y); TRACE_MODE 1: y_new = s ? min(d(y)+Y_INC, 2^TRACE_W-1) : d(y); intermediate sums SHALL be computed one bit wider.
REQ-013 At commit, o_y2_trace_buf SHALL load the pre-update y2 values, and the y2 register SHALL take the updated values.
REQ-014 At commit, post_cnt[k] SHALL increment when s = 1 and SHALL saturate at 2^CNT_W-1.
REQ-015 At commit, spike_buffer SHALL clear; an i_valid spike accepted in the commit cycle SHALL set its bit (set wins over clear).
REQ-016 The first accepted spike of a step SHALL load o_inhbt and set o_inhbt_valid; later spikes in the same step SHALL not change either; o_inhbt_valid SHALL clear at commit unless that cycle carries a new first spike.
REQ-017 i_cnt_clr SHALL zero all counters and SHALL take priority over a simultaneous commit increment.
REQ-018 i_s_init SHALL zero spike_buffer, traces, y2_trace_buf, counters, the step counter and the inhibit outputs; it SHALL override all other inputs and SHALL suppress o_valid in that cycle.

Reset
REQ-019 reset_n low SHALL asynchronously force every register and every output to 0.
REQ-020 Deassertion of reset_n mid-step SHALL leave the block in the cleared state; results from the partial step SHALL be lost.

Structure
REQ-021 The trace-update arithmetic SHALL be a sub-module trace_update, instantiated N_NEURON times through generate.
REQ-022 Shared package snn_pkg SHALL hold the TRACE_MODE encodings and the default widths (TRACE_W, CNT_W, IDX_W).
REQ-023 All outputs SHALL be registered.

Verification
REQ-024 Scenario, 18 results with neuron 3 spiking only, TRACE_MODE 0: o_valid pulses once, y1[3] = 65535, y1 of all others = 0, post_cnt[3] = 1, o_inhbt = 3.
REQ-025 Scenario, next step with no spikes: y1[3] = 61440, y2[3] = 63488, y2_trace_buf[3] = 65535.
REQ-026 Scenario, TRACE_MODE 1, neuron 0 spiking every step from 0: y1[0] = 16384, then 31744, then 46144; the value saturates at 65535 and never wraps.
REQ-027 Scenario, neuron 5 spiking for 130 steps with CNT_W = 7: post_cnt[5] = 127; then i_cnt_clr asserted in a commit cycle gives post_cnt = 0.
REQ-028 Scenario, spikes on idx 7 then idx 2 in one step, plus idx 20 with i_spike = 1: o_inhbt = 7, idx 20 is ignored, and commit occurs only after 18 in-range results.
REQ-029 Scenario, reset_n pulsed low after 9 results: all outputs are 0; 18 further results are needed to reach the next o_valid.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared encodings and default widths for the SNN post-synaptic datapath.
package snn_pkg;

  localparam int TM_MAX = 0;
  localparam int TM_ADD = 1;

  localparam int TRACE_W_DEF = 16;
  localparam int CNT_W_DEF   = 7;
  localparam int IDX_W_DEF   = 5;

endpackage

// File: rtl/post_trace_array_if.sv
// Neuron-result stream feeding post_trace_array, plus its control strobes.
interface post_trace_array_if
  import snn_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) ();

  logic             valid;
  logic             spike;
  logic [IDX_W-1:0] idx;
  logic             s_init;
  logic             cnt_clr;

  modport master (
    output valid, spike, idx, s_init, cnt_clr
  );

  modport slave (
    input valid, spike, idx, s_init, cnt_clr
  );

endinterface

// File: rtl/trace_update.sv
// Single-trace decay / spike update, evaluated one bit wider than the trace.
module trace_update
  import snn_pkg::*;
#(
  parameter int TRACE_W = TRACE_W_DEF,
  parameter int SHIFT   = 4,
  parameter int MODE    = TM_MAX,
  parameter int Y_INC   = 16384
) (
  input  logic               s_i,
  input  logic [TRACE_W-1:0] y_i,
  output logic [TRACE_W-1:0] y_o
);

  localparam logic [TRACE_W:0] MAXV = {1'b0, {TRACE_W{1'b1}}};
  localparam logic [TRACE_W:0] INC  = (TRACE_W+1)'(Y_INC);

  logic [TRACE_W:0] ext;
  logic [TRACE_W:0] dec;
  logic [TRACE_W:0] sum;

  always_comb begin
    ext = {1'b0, y_i};
    dec = ext - (ext >> SHIFT);
    sum = dec + INC;
    y_o = dec[TRACE_W-1:0];
    if (s_i) begin
      if (MODE == TM_MAX) y_o = MAXV[TRACE_W-1:0];
      else if (sum > MAXV) y_o = MAXV[TRACE_W-1:0];
      else y_o = sum[TRACE_W-1:0];
    end
  end

endmodule

// File: rtl/post_trace_array.sv
// Per-step spike capture, trace decay/update, spike counting and
// first-spike inhibit tracking for N_NEURON post-synaptic neurons.
module post_trace_array
  import snn_pkg::*;
#(
  parameter int N_NEURON   = 18,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int TRACE_W    = TRACE_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int Y1_SHIFT   = 4,
  parameter int Y2_SHIFT   = 5,
  parameter int TRACE_MODE = TM_MAX,
  parameter int Y_INC      = 16384
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_valid,
  input  logic                        i_spike,
  input  logic [IDX_W-1:0]            i_neuron_idx,
  input  logic                        i_s_init,
  input  logic                        i_cnt_clr,
  output logic [N_NEURON-1:0]         o_spike_buffer,
  output logic [N_NEURON*TRACE_W-1:0] o_y1_trace,
  output logic [N_NEURON*TRACE_W-1:0] o_y2_trace_buf,
  output logic [IDX_W-1:0]            o_inhbt,
  output logic                        o_inhbt_valid,
  output logic [N_NEURON*CNT_W-1:0]   o_post_cnt,
  output logic                        o_valid
);

  localparam int STEP_W = $clog2(N_NEURON + 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(N_NEURON - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [N_NEURON-1:0] ONE = {{(N_NEURON-1){1'b0}}, 1'b1};

  logic [N_NEURON-1:0]               spike_q;
  logic [N_NEURON-1:0][TRACE_W-1:0]  y1_q;
  logic [N_NEURON-1:0][TRACE_W-1:0]  y2_q;
  logic [N_NEURON-1:0][TRACE_W-1:0]  y2buf_q;
  logic [N_NEURON-1:0][CNT_W-1:0]    cnt_q;
  logic [STEP_W-1:0]                 step_q;
  logic [IDX_W-1:0]                  inhbt_q;
  logic                              inhv_q;
  logic                              commit_q;

  logic [N_NEURON-1:0][TRACE_W-1:0]  y1_d;
  logic [N_NEURON-1:0][TRACE_W-1:0]  y2_d;
  logic [N_NEURON-1:0][CNT_W-1:0]    cnt_d;
  logic [N_NEURON-1:0]               set_d;
  logic                              accept;
  logic                              first_d;

  assign accept = i_valid && (32'(i_neuron_idx) < N_NEURON);
  assign set_d  = (accept && i_spike) ? (ONE << i_neuron_idx) : '0;
  // The commit cycle opens a new step, so the old inhibit flag no longer blocks.
  assign first_d = accept && i_spike && !(inhv_q && !commit_q);

  for (genvar k = 0; k < N_NEURON; k++) begin : g_n
    trace_update #(
      .TRACE_W(TRACE_W),
      .SHIFT  (Y1_SHIFT),
      .MODE   (TRACE_MODE),
      .Y_INC  (Y_INC)
    ) u_y1 (
      .s_i(spike_q[k]),
      .y_i(y1_q[k]),
      .y_o(y1_d[k])
    );

    trace_update #(
      .TRACE_W(TRACE_W),
      .SHIFT  (Y2_SHIFT),
      .MODE   (TRACE_MODE),
      .Y_INC  (Y_INC)
    ) u_y2 (
      .s_i(spike_q[k]),
      .y_i(y2_q[k]),
      .y_o(y2_d[k])
    );

    assign cnt_d[k] = (spike_q[k] && cnt_q[k] != CNT_MAX)
                    ? cnt_q[k] + 1'b1 : cnt_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_q  <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      y2buf_q  <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      inhbt_q  <= '0;
      inhv_q   <= 1'b0;
      commit_q <= 1'b0;
    end else if (i_s_init) begin
      spike_q  <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      y2buf_q  <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      inhbt_q  <= '0;
      inhv_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (accept) begin
        if (step_q == LAST) begin
          step_q   <= '0;
          commit_q <= 1'b1;
        end else begin
          step_q <= step_q + 1'b1;
        end
      end
      if (commit_q) begin
        spike_q <= set_d;
        y1_q    <= y1_d;
        y2_q    <= y2_d;
        y2buf_q <= y2_q;
      end else begin
        spike_q <= spike_q | set_d;
      end
      if (i_cnt_clr) cnt_q <= '0;
      else if (commit_q) cnt_q <= cnt_d;
      if (first_d) begin
        inhbt_q <= i_neuron_idx;
        inhv_q  <= 1'b1;
      end else if (commit_q) begin
        inhv_q <= 1'b0;
      end
    end
  end

  assign o_spike_buffer = spike_q;
  assign o_y1_trace     = y1_q;
  assign o_y2_trace_buf = y2buf_q;
  assign o_post_cnt     = cnt_q;
  assign o_inhbt        = inhbt_q;
  assign o_inhbt_valid  = inhv_q;
  assign o_valid        = commit_q;

endmodule

// File: tb/tb_post_trace_array.sv
// Directed bench: one set-to-max instance and one additive instance share stimulus.
module tb_post_trace_array;
  import snn_pkg::*;

  localparam int N  = 18;
  localparam int TW = 16;
  localparam int CW = 7;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  post_trace_array_if #(.IDX_W(IW)) bus ();

  logic [N-1:0]    sb0, sb1;
  logic [N*TW-1:0] y1_0, y1_1, y2b0, y2b1;
  logic [IW-1:0]   inh0, inh1;
  logic            inhv0, inhv1, v0, v1;
  logic [N*CW-1:0] cnt0, cnt1;

  post_trace_array #(.TRACE_MODE(TM_MAX)) u0 (
    .clk(clk), .reset_n(reset_n),
    .i_valid(bus.valid), .i_spike(bus.spike),
    .i_neuron_idx(bus.idx), .i_s_init(bus.s_init),
    .i_cnt_clr(bus.cnt_clr),
    .o_spike_buffer(sb0), .o_y1_trace(y1_0),
    .o_y2_trace_buf(y2b0), .o_inhbt(inh0),
    .o_inhbt_valid(inhv0), .o_post_cnt(cnt0),
    .o_valid(v0)
  );

  post_trace_array #(.TRACE_MODE(TM_ADD)) u1 (
    .clk(clk), .reset_n(reset_n),
    .i_valid(bus.valid), .i_spike(bus.spike),
    .i_neuron_idx(bus.idx), .i_s_init(bus.s_init),
    .i_cnt_clr(bus.cnt_clr),
    .o_spike_buffer(sb1), .o_y1_trace(y1_1),
    .o_y2_trace_buf(y2b1), .o_inhbt(inh1),
    .o_inhbt_valid(inhv1), .o_post_cnt(cnt1),
    .o_valid(v1)
  );

  int npass = 0;
  int ntotal = 0;
  int vp = 0;

  function automatic logic [TW-1:0] tr(input logic [N*TW-1:0] v, input int k);
    return v[k*TW +: TW];
  endfunction

  function automatic logic [CW-1:0] cn(input logic [N*CW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction

  task automatic send(input int idx, input logic spk);
    @(negedge clk);
    if (v0) vp++;
    bus.valid = 1'b1;
    bus.idx = IW'(idx);
    bus.spike = spk;
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    if (v0) vp++;
    bus.valid = 1'b0;
    bus.spike = 1'b0;
    bus.cnt_clr = clr;
  endtask

  task automatic run_step(input logic [N-1:0] mask);
    vp = 0;
    for (int i = 0; i < N; i++) send(i, mask[i]);
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic do_init();
    @(negedge clk);
    bus.valid = 1'b0;
    bus.spike = 1'b0;
    bus.s_init = 1'b1;
    @(negedge clk);
    bus.s_init = 1'b0;
  endtask

  task automatic test_reset();
    ntotal++; if (v0 !== 1'b0) $display("FAIL rst_valid got %0b want 0", v0); else npass++;
    ntotal++; if (sb0 !== '0) $display("FAIL rst_spkbuf got %h want 0", sb0); else npass++;
    ntotal++; if (y1_0 !== '0) $display("FAIL rst_y1 got %h want 0", y1_0); else npass++;
    ntotal++; if (y2b0 !== '0) $display("FAIL rst_y2buf got %h want 0", y2b0); else npass++;
    ntotal++; if (cnt0 !== '0) $display("FAIL rst_cnt got %h want 0", cnt0); else npass++;
    ntotal++; if (inh0 !== '0) $display("FAIL rst_inhbt got %0d want 0", inh0); else npass++;
    ntotal++; if (inhv0 !== 1'b0) $display("FAIL rst_inhv got %0b want 0", inhv0); else npass++;
  endtask

  task automatic test_single_spike();
    logic [N*TW-1:0] exp;
    exp = '0;
    exp[3*TW +: TW] = 16'hFFFF;
    run_step(18'(1) << 3);
    ntotal++; if (vp !== 1) $display("FAIL s1_pulses got %0d want 1", vp); else npass++;
    ntotal++; if (y1_0 !== exp) $display("FAIL s1_y1 got %h want %h", y1_0, exp); else npass++;
    ntotal++; if (cn(cnt0, 3) !== 7'd1) $display("FAIL s1_cnt3 got %0d want 1", cn(cnt0, 3)); else npass++;
    ntotal++; if (inh0 !== 5'd3) $display("FAIL s1_inhbt got %0d want 3", inh0); else npass++;
    ntotal++; if (inhv0 !== 1'b0) $display("FAIL s1_inhv got %0b want 0", inhv0); else npass++;
    ntotal++; if (sb0 !== '0) $display("FAIL s1_spkbuf got %h want 0", sb0); else npass++;
    ntotal++; if (tr(y1_1, 3) !== 16'd16384) $display("FAIL s1_add_y1 got %0d want 16384", tr(y1_1, 3)); else npass++;
  endtask

  task automatic test_decay();
    run_step('0);
    ntotal++; if (tr(y1_0, 3) !== 16'd61440) $display("FAIL d1_y1 got %0d want 61440", tr(y1_0, 3)); else npass++;
    ntotal++; if (tr(y2b0, 3) !== 16'd65535) $display("FAIL d1_y2buf got %0d want 65535", tr(y2b0, 3)); else npass++;
    ntotal++; if (cn(cnt0, 3) !== 7'd1) $display("FAIL d1_cnt3 got %0d want 1", cn(cnt0, 3)); else npass++;
    run_step('0);
    ntotal++; if (tr(y2b0, 3) !== 16'd63488) $display("FAIL d2_y2buf got %0d want 63488", tr(y2b0, 3)); else npass++;
    ntotal++; if (tr(y1_0, 3) !== 16'd57600) $display("FAIL d2_y1 got %0d want 57600", tr(y1_0, 3)); else npass++;
  endtask

  task automatic test_additive();
    int exp_tab[6] = '{16384, 31744, 46144, 59644, 65535, 65535};
    do_init();
    ntotal++; if (y1_1 !== '0) $display("FAIL init_y1 got %h want 0", y1_1); else npass++;
    for (int s = 0; s < 6; s++) begin
      run_step(18'(1));
      ntotal++;
      if (tr(y1_1, 0) !== 16'(exp_tab[s]))
        $display("FAIL add_y1_step%0d got %0d want %0d", s, tr(y1_1, 0), exp_tab[s]);
      else npass++;
    end
    ntotal++; if (tr(y1_0, 0) !== 16'hFFFF) $display("FAIL max_y1 got %0d want 65535", tr(y1_0, 0)); else npass++;
  endtask

  task automatic test_cnt_sat();
    logic [N-1:0] m5;
    m5 = 18'(1) << 5;
    do_init();
    for (int s = 0; s < 127; s++) run_step(m5);
    ntotal++; if (cn(cnt0, 5) !== 7'd127) $display("FAIL cnt_127 got %0d want 127", cn(cnt0, 5)); else npass++;
    for (int s = 0; s < 3; s++) run_step(m5);
    ntotal++; if (cn(cnt0, 5) !== 7'd127) $display("FAIL cnt_sat got %0d want 127", cn(cnt0, 5)); else npass++;
    vp = 0;
    for (int i = 0; i < N; i++) send(i, m5[i]);
    idle(1'b1);
    idle(1'b0);
    ntotal++; if (vp !== 1) $display("FAIL clr_pulses got %0d want 1", vp); else npass++;
    ntotal++; if (cnt0 !== '0) $display("FAIL cnt_clr got %h want 0", cnt0); else npass++;
  endtask

  task automatic test_out_of_range();
    logic [N*TW-1:0] exp;
    exp = '0;
    exp[7*TW +: TW] = 16'hFFFF;
    exp[2*TW +: TW] = 16'hFFFF;
    do_init();
    vp = 0;
    send(7, 1'b1);
    send(2, 1'b1);
    send(20, 1'b1);
    for (int i = 0; i < 17; i++)
      if (i != 7 && i != 2) send(i, 1'b0);
    idle(1'b0);
    ntotal++; if (vp !== 0) $display("FAIL oor_early got %0d want 0", vp); else npass++;
    ntotal++; if (inh0 !== 5'd7) $display("FAIL oor_inhbt got %0d want 7", inh0); else npass++;
    ntotal++; if (inhv0 !== 1'b1) $display("FAIL oor_inhv got %0b want 1", inhv0); else npass++;
    ntotal++; if (sb0 !== 18'h00084) $display("FAIL oor_spkbuf got %h want 00084", sb0); else npass++;
    send(17, 1'b0);
    idle(1'b0);
    idle(1'b0);
    ntotal++; if (vp !== 1) $display("FAIL oor_commit got %0d want 1", vp); else npass++;
    ntotal++; if (y1_0 !== exp) $display("FAIL oor_y1 got %h want %h", y1_0, exp); else npass++;
    ntotal++; if (inh0 !== 5'd7) $display("FAIL oor_inhbt2 got %0d want 7", inh0); else npass++;
  endtask

  task automatic test_back_to_back();
    do_init();
    vp = 0;
    for (int i = 0; i < N; i++) send(i, 1'b0);
    send(9, 1'b1);
    idle(1'b0);
    ntotal++; if (vp !== 1) $display("FAIL b2b_pulses got %0d want 1", vp); else npass++;
    ntotal++; if (sb0 !== 18'h00200) $display("FAIL b2b_spkbuf got %h want 00200", sb0); else npass++;
    ntotal++; if (inh0 !== 5'd9) $display("FAIL b2b_inhbt got %0d want 9", inh0); else npass++;
    ntotal++; if (inhv0 !== 1'b1) $display("FAIL b2b_inhv got %0b want 1", inhv0); else npass++;
    do_init();
    ntotal++; if (sb0 !== '0) $display("FAIL init_spkbuf got %h want 0", sb0); else npass++;
    ntotal++; if (inhv0 !== 1'b0) $display("FAIL init_inhv got %0b want 0", inhv0); else npass++;
  endtask

  task automatic test_reset_mid();
    do_init();
    for (int i = 0; i < 9; i++) send(i, i == 4);
    @(negedge clk);
    bus.valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    ntotal++; if (sb0 !== '0) $display("FAIL rm_spkbuf got %h want 0", sb0); else npass++;
    ntotal++; if (inhv0 !== 1'b0) $display("FAIL rm_inhv got %0b want 0", inhv0); else npass++;
    ntotal++; if (inh0 !== '0) $display("FAIL rm_inhbt got %0d want 0", inh0); else npass++;
    @(negedge clk);
    reset_n = 1'b1;
    vp = 0;
    for (int i = 0; i < 17; i++) send(i, 1'b0);
    idle(1'b0);
    ntotal++; if (vp !== 0) $display("FAIL rm_early got %0d want 0", vp); else npass++;
    send(17, 1'b0);
    idle(1'b0);
    idle(1'b0);
    ntotal++; if (vp !== 1) $display("FAIL rm_commit got %0d want 1", vp); else npass++;
    ntotal++; if (y1_0 !== '0) $display("FAIL rm_y1 got %h want 0", y1_0); else npass++;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.valid = 1'b0;
    bus.spike = 1'b0;
    bus.idx = '0;
    bus.s_init = 1'b0;
    bus.cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_single_spike();
    test_decay();
    test_additive();
    test_cnt_sat();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
